// File: rtl/geri_yaz_hakem.sv
// Register-file write-port arbiter: in-order writeback vs. a one-entry buffered long-latency result.
// Optional wait-conflict counter output enabled by GERIYAZ_CAKISMA_SAYAC_EN.
module geri_yaz_hakem #(
   parameter int unsigned MAX_BEKLEME = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        yrt_yaz_i,
   input  logic [4:0]  yrt_rd_adres_i,
   input  logic [31:0] yrt_rd_deger_i,
   input  logic        cok_gecerli_i,
   output logic        cok_hazir_o,
   input  logic [4:0]  cok_rd_adres_i,
   input  logic [31:0] cok_rd_deger_i,
   output logic        yrt_durdur_o,
   output logic        cyo_yaz_yazmac_o,
   output logic [4:0]  cyo_yaz_adres_o,
   output logic [31:0] cyo_yaz_deger_o
`ifdef GERIYAZ_CAKISMA_SAYAC_EN
   ,
   output logic [31:0] cakisma_sayisi_o
`endif
);

   typedef enum logic [1:0] {
      BOS      = 2'b00,
      BEKLIYOR = 2'b01,
      ZORLA    = 2'b10
   } durum_t;

   localparam logic [3:0] LP_MAX = 4'(MAX_BEKLEME);

   durum_t      r_durum, w_durum_sonraki;
   logic [3:0]  r_sayac, w_sayac_sonraki;
   logic [4:0]  r_tam_adres;
   logic [31:0] r_tam_deger;
   logic        r_yaz;
   logic [4:0]  r_adres;
   logic [31:0] r_deger;

   logic        w_p;
   logic        w_aktar;
   logic        w_cok_etkin;
   logic        w_yaz;
   logic [4:0]  w_adres;
   logic [31:0] w_deger;
   logic        w_yakala;

   assign w_p         = yrt_yaz_i && (yrt_rd_adres_i != 5'd0);
   assign cok_hazir_o = (r_durum == BOS);
   assign yrt_durdur_o = (r_durum == ZORLA);
   assign w_aktar     = cok_gecerli_i && cok_hazir_o;
   // A transferred result aimed at x0 is consumed without ever touching the port.
   assign w_cok_etkin = w_aktar && (cok_rd_adres_i != 5'd0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_durum     <= BOS;
         r_sayac     <= 4'd0;
         r_tam_adres <= 5'd0;
         r_tam_deger <= 32'd0;
      end else begin
         r_durum <= w_durum_sonraki;
         r_sayac <= w_sayac_sonraki;
         if (w_yakala) begin
            r_tam_adres <= cok_rd_adres_i;
            r_tam_deger <= cok_rd_deger_i;
         end
      end
   end

   always_comb begin
      w_durum_sonraki = r_durum;
      w_sayac_sonraki = r_sayac;
      w_yaz           = 1'b0;
      w_adres         = yrt_rd_adres_i;
      w_deger         = yrt_rd_deger_i;
      w_yakala        = 1'b0;
      case (r_durum)
         BOS: begin
            if (w_cok_etkin && !w_p) begin
               w_yaz   = 1'b1;
               w_adres = cok_rd_adres_i;
               w_deger = cok_rd_deger_i;
            end else if (w_cok_etkin && (cok_rd_adres_i != yrt_rd_adres_i)) begin
               w_yaz           = 1'b1;
               w_yakala        = 1'b1;
               w_sayac_sonraki = 4'd0;
               w_durum_sonraki = BEKLIYOR;
            end else if (w_p) begin
               // Same-rd collision lands here too: the younger pipeline value wins.
               w_yaz = 1'b1;
            end
         end
         BEKLIYOR: begin
            if (!w_p) begin
               w_yaz           = 1'b1;
               w_adres         = r_tam_adres;
               w_deger         = r_tam_deger;
               w_sayac_sonraki = 4'd0;
               w_durum_sonraki = BOS;
            end else if (yrt_rd_adres_i == r_tam_adres) begin
               w_yaz           = 1'b1;
               w_sayac_sonraki = 4'd0;
               w_durum_sonraki = BOS;
            end else begin
               w_yaz           = 1'b1;
               w_sayac_sonraki = r_sayac + 4'd1;
               if (r_sayac + 4'd1 == LP_MAX)
                  w_durum_sonraki = ZORLA;
            end
         end
         ZORLA: begin
            w_yaz           = 1'b1;
            w_adres         = r_tam_adres;
            w_deger         = r_tam_deger;
            w_sayac_sonraki = 4'd0;
            w_durum_sonraki = BOS;
         end
         default: begin
            w_sayac_sonraki = 4'd0;
            w_durum_sonraki = BOS;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_yaz   <= 1'b0;
         r_adres <= 5'd0;
         r_deger <= 32'd0;
      end else begin
         r_yaz <= w_yaz;
         if (w_yaz) begin
            r_adres <= w_adres;
            r_deger <= w_deger;
         end
      end
   end

   assign cyo_yaz_yazmac_o = r_yaz;
   assign cyo_yaz_adres_o  = r_adres;
   assign cyo_yaz_deger_o  = r_deger;

`ifdef GERIYAZ_CAKISMA_SAYAC_EN
   logic [31:0] r_cakisma;
   logic        w_cakisma;

   // Buffered entry always competes; in BOS only a presented non-x0 result does.
   assign w_cakisma = w_p && ((r_durum == BOS) ? (cok_gecerli_i && (cok_rd_adres_i != 5'd0)) : 1'b1);

   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_cakisma <= 32'd0;
      else if (w_cakisma)
         r_cakisma <= r_cakisma + 32'd1;
   end

   assign cakisma_sayisi_o = r_cakisma;
`endif

endmodule

// File: tb/tb_geri_yaz_hakem.sv
// Directed plus randomized bench for geri_yaz_hakem against a queue-based reference model.
module tb_geri_yaz_hakem;

   localparam int MAXB = 4;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        yrt_yaz_i;
   logic [4:0]  yrt_rd_adres_i;
   logic [31:0] yrt_rd_deger_i;
   logic        cok_gecerli_i;
   logic        cok_hazir_o;
   logic [4:0]  cok_rd_adres_i;
   logic [31:0] cok_rd_deger_i;
   logic        yrt_durdur_o;
   logic        cyo_yaz_yazmac_o;
   logic [4:0]  cyo_yaz_adres_o;
   logic [31:0] cyo_yaz_deger_o;
`ifdef GERIYAZ_CAKISMA_SAYAC_EN
   logic [31:0] cakisma_sayisi_o;
`endif

   geri_yaz_hakem #(.MAX_BEKLEME(MAXB)) dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .yrt_yaz_i        (yrt_yaz_i),
      .yrt_rd_adres_i   (yrt_rd_adres_i),
      .yrt_rd_deger_i   (yrt_rd_deger_i),
      .cok_gecerli_i    (cok_gecerli_i),
      .cok_hazir_o      (cok_hazir_o),
      .cok_rd_adres_i   (cok_rd_adres_i),
      .cok_rd_deger_i   (cok_rd_deger_i),
      .yrt_durdur_o     (yrt_durdur_o),
      .cyo_yaz_yazmac_o (cyo_yaz_yazmac_o),
      .cyo_yaz_adres_o  (cyo_yaz_adres_o),
      .cyo_yaz_deger_o  (cyo_yaz_deger_o)
`ifdef GERIYAZ_CAKISMA_SAYAC_EN
      ,
      .cakisma_sayisi_o (cakisma_sayisi_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] v;
   } ent_t;

   // Reference model: pending long-latency results, how many times the pending one lost, forced-drain flag.
   ent_t        m_buf[$];
   int          m_kayip;
   bit          m_zorla;
   logic        m_we;
   logic [4:0]  m_ad;
   logic [31:0] m_dg;
   logic [31:0] m_cak;

   int n_vec = 0;
   int n_err = 0;

   // Bench-side long-latency unit: holds its result until accepted.
   bit          pend_v;
   logic [4:0]  pend_rd;
   logic [31:0] pend_dg;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_buf.delete();
      m_kayip = 0;
      m_zorla = 0;
      m_we = 0; m_ad = 0; m_dg = 0;
      m_cak = 0;
   endtask

   task automatic do_reset();
      rst_i = 1; yrt_yaz_i = 0; yrt_rd_adres_i = 0; yrt_rd_deger_i = 0;
      cok_gecerli_i = 0; cok_rd_adres_i = 0; cok_rd_deger_i = 0;
      pend_v = 0;
      @(posedge clk); #1;
      model_reset();
      rst_i = 0;
      chk("rst_yazmac", 32'(cyo_yaz_yazmac_o), 0);
      chk("rst_adres", 32'(cyo_yaz_adres_o), 0);
      chk("rst_deger", cyo_yaz_deger_o, 0);
      chk("rst_hazir", 32'(cok_hazir_o), 1);
      chk("rst_durdur", 32'(yrt_durdur_o), 0);
   endtask

   // Apply one cycle of inputs, check handshake/stall, then the registered write.
   task automatic step(input bit yaz, input logic [4:0] rd, input logic [31:0] dg,
                       input bit cg, input logic [4:0] crd, input logic [31:0] cdg,
                       output bit xfer);
      bit   p, hz;
      bit   we;
      ent_t w;
      yrt_yaz_i = yaz; yrt_rd_adres_i = rd; yrt_rd_deger_i = dg;
      cok_gecerli_i = cg; cok_rd_adres_i = crd; cok_rd_deger_i = cdg;
      #1;
      p  = yaz && (rd != 0);
      hz = (m_buf.size() == 0) && !m_zorla;
      chk("hazir", 32'(cok_hazir_o), 32'(hz));
      chk("durdur", 32'(yrt_durdur_o), 32'(m_zorla));
      xfer = hz && cg;
      we = 0; w = '0;
      if (p && (!hz || (cg && crd != 0))) m_cak++;
      if (m_zorla) begin
         w = m_buf.pop_front(); we = 1;
         m_zorla = 0; m_kayip = 0;
      end else if (m_buf.size() != 0) begin
         if (!p) begin
            w = m_buf.pop_front(); we = 1; m_kayip = 0;
         end else begin
            w = '{rd: rd, v: dg}; we = 1;
            if (rd == m_buf[0].rd) begin
               void'(m_buf.pop_front()); m_kayip = 0;
            end else begin
               m_kayip++;
               if (m_kayip == MAXB) m_zorla = 1;
            end
         end
      end else begin
         if (xfer && crd != 0 && !p) begin
            w = '{rd: crd, v: cdg}; we = 1;
         end else if (p) begin
            w = '{rd: rd, v: dg}; we = 1;
            if (xfer && crd != 0 && crd != rd) begin
               m_buf.push_back('{rd: crd, v: cdg});
               m_kayip = 0;
            end
         end
      end
      m_we = we;
      if (we) begin m_ad = w.rd; m_dg = w.v; end
      @(posedge clk); #1;
      chk("yazmac", 32'(cyo_yaz_yazmac_o), 32'(m_we));
      chk("adres", 32'(cyo_yaz_adres_o), 32'(m_ad));
      chk("deger", cyo_yaz_deger_o, m_dg);
`ifdef GERIYAZ_CAKISMA_SAYAC_EN
      chk("cakisma", cakisma_sayisi_o, m_cak);
`endif
   endtask

   initial begin
      bit x;
      bit yz;
      logic [4:0] rd;
      logic [31:0] dg;

      do_reset();

      // Pipeline only, then long-latency only
      step(1, 5'd5, 32'h1234, 0, 0, 0, x);
      step(0, 0, 0, 1, 5'd7, 32'hDEAD, x);
      chk("ll_only_adres", 32'(cyo_yaz_adres_o), 7);
      chk("ll_only_deger", cyo_yaz_deger_o, 32'hDEAD);

      // Conflict then gap
      step(1, 5'd3, 32'h33, 1, 5'd9, 32'h99, x);
      chk("conf_p_adres", 32'(cyo_yaz_adres_o), 3);
      chk("conf_hazir0", 32'(cok_hazir_o), 0);
      step(0, 0, 0, 0, 0, 0, x);
      chk("gap_buf_adres", 32'(cyo_yaz_adres_o), 9);
      chk("gap_hazir1", 32'(cok_hazir_o), 1);

      // Starvation: buffered rd 2 loses MAXB cycles, then one forced cycle
      step(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, x);
      for (int i = 0; i < MAXB; i++) step(1, 5'(10 + i), 32'(i), 0, 0, 0, x);
      chk("starve_durdur", 32'(yrt_durdur_o), 1);
      step(1, 5'd20, 32'hBAD, 0, 0, 0, x);
      chk("starve_adres", 32'(cyo_yaz_adres_o), 2);
      chk("starve_deger", cyo_yaz_deger_o, 32'h22);
      chk("starve_durdur_off", 32'(yrt_durdur_o), 0);

      // WAW against buffer, then same-cycle WAW
      step(1, 5'd1, 32'h1, 1, 5'd4, 32'h44, x);
      step(1, 5'd4, 32'h55, 0, 0, 0, x);
      chk("waw_deger", cyo_yaz_deger_o, 32'h55);
      chk("waw_hazir", 32'(cok_hazir_o), 1);
      step(0, 0, 0, 0, 0, 0, x);
      step(1, 5'd4, 32'h55, 1, 5'd4, 32'h44, x);
      step(0, 0, 0, 0, 0, 0, x);

      // x0 pipeline request with a long-latency result
      step(1, 5'd0, 32'hFF, 1, 5'd6, 32'h66, x);
      chk("x0_adres", 32'(cyo_yaz_adres_o), 6);
      step(0, 0, 0, 1, 5'd0, 32'h77, x);

      // Reset while a result is buffered
      step(1, 5'd1, 32'h1, 1, 5'd8, 32'h88, x);
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, x);

      // Randomized traffic with a small register range to provoke collisions
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            if (!pend_v && $urandom_range(0, 2) == 0) begin
               pend_v = 1;
               pend_rd = 5'($urandom_range(0, 7));
               pend_dg = $urandom;
            end
            yz = ($urandom_range(0, 9) < 8);
            rd = 5'($urandom_range(0, 7));
            dg = $urandom;
            step(yz, rd, dg, pend_v, pend_v ? pend_rd : 5'd0, pend_v ? pend_dg : 32'd0, x);
            if (x) pend_v = 0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
